// File: rtl/serv_bufreg_seq_if.sv
// serv_bufreg_seq_if
// Groups the operation request, buffer-register strobes and data-bus handshake
// of the SERV buffer-register sequencer into one bundle.
//   slave  modport : used by the sequencer (takes i_*, drives o_*)
//   master modport : used by the decode/state side or a testbench
// Signals:
//   i_start/i_mem/i_we/i_size : operation request, sampled in IDLE
//   i_lsb                     : buffer register address LSBs (alignment check)
//   i_dbus_ack                : data-bus acknowledge
//   o_busy/o_init/o_bufreg_en : sequencer status and buffer register strobes
//   o_cnt/o_cnt0/o_cnt1/o_cnt_done : serial bit counter and its decodes
//   o_dbus_cyc/o_dbus_we      : data-bus request
//   o_rd_en                   : load writeback shift enable
//   o_done/o_trap/o_bus_err   : one-cycle completion / misalignment / timeout
interface serv_bufreg_seq_if;
  logic       i_start;
  logic       i_mem;
  logic       i_we;
  logic [1:0] i_size;
  logic [1:0] i_lsb;
  logic       i_dbus_ack;
  logic       o_busy;
  logic       o_init;
  logic       o_bufreg_en;
  logic [4:0] o_cnt;
  logic       o_cnt0;
  logic       o_cnt1;
  logic       o_cnt_done;
  logic       o_dbus_cyc;
  logic       o_dbus_we;
  logic       o_rd_en;
  logic       o_done;
  logic       o_trap;
  logic       o_bus_err;

  modport slave (
    input  i_start, i_mem, i_we, i_size, i_lsb, i_dbus_ack,
    output o_busy, o_init, o_bufreg_en, o_cnt, o_cnt0, o_cnt1, o_cnt_done,
           o_dbus_cyc, o_dbus_we, o_rd_en, o_done, o_trap, o_bus_err
  );

  modport master (
    output i_start, i_mem, i_we, i_size, i_lsb, i_dbus_ack,
    input  o_busy, o_init, o_bufreg_en, o_cnt, o_cnt0, o_cnt1, o_cnt_done,
           o_dbus_cyc, o_dbus_we, o_rd_en, o_done, o_trap, o_bus_err
  );
endinterface

// File: rtl/serv_bufreg_seq.sv
// serv_bufreg_seq
// Bit-serial sequencer for the SERV buffer register and its data-bus access.
// An accepted operation runs a 32-cycle INIT pass (rs1+imm accumulation into
// the buffer register), then for memory ops checks alignment, holds the dbus
// request until ack (optionally bounded by TIMEOUT), and for loads runs the
// 32-cycle writeback pass. DONE/TRAP/ERR are one-cycle pulse states.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : serv_bufreg_seq_if.slave (request, strobes, dbus handshake)
// Parameters:
//   TIMEOUT : ack timeout in BUS cycles, 0 disables it
//   TMO_W   : wait counter width, TIMEOUT < 2**TMO_W
module serv_bufreg_seq #(
  parameter int TIMEOUT = 0,
  parameter int TMO_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  serv_bufreg_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_BUS  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_TRAP = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  localparam bit             TMO_EN   = (TIMEOUT > 0);
  // Last wait count before the timeout fires; only used when TMO_EN is set.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [TMO_W-1:0] r_wait;
  logic             r_mem;
  logic             r_we;
  logic [1:0]       r_size;

  logic             w_serial;

  // Byte accesses are never misaligned; size 11 is handled as a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic res;
    case (size)
      2'b00:   res = 1'b0;
      2'b01:   res = lsb[0];
      default: res = (lsb != 2'b00);
    endcase
    return res;
  endfunction

  // Sequencer state, serial counter, bus wait counter and captured op fields.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
      r_wait  <= '0;
      r_mem   <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_mem   <= bus.i_mem;
            r_we    <= bus.i_we;
            r_size  <= bus.i_size;
            r_cnt   <= 5'd0;
            r_state <= ST_INIT;
          end
        end
        ST_INIT: begin
          r_cnt <= r_cnt + 5'd1;  // wraps to 0 after 31
          if (r_cnt == 5'd31) begin
            if (!r_mem) begin
              r_state <= ST_DONE;
            end else if (misaligned(r_size, bus.i_lsb)) begin
              r_state <= ST_TRAP;
            end else begin
              r_wait  <= '0;
              r_state <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          // Ack has priority over a timeout reached in the same cycle.
          if (bus.i_dbus_ack) begin
            r_cnt   <= 5'd0;
            r_state <= r_we ? ST_DONE : ST_RUN;
          end else if (TMO_EN) begin
            if (r_wait == TMO_LAST) begin
              r_state <= ST_ERR;
            end else begin
              r_wait <= r_wait + {{(TMO_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE, ST_TRAP, ST_ERR: begin
          r_cnt   <= 5'd0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cnt   <= 5'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // All outputs are pure decodes of registered state, so reset clears them at once.
  assign w_serial        = (r_state == ST_INIT) || (r_state == ST_RUN);

  assign bus.o_busy      = (r_state != ST_IDLE);
  assign bus.o_init      = (r_state == ST_INIT);
  assign bus.o_bufreg_en = (r_state == ST_INIT);
  assign bus.o_cnt       = w_serial ? r_cnt : 5'd0;
  assign bus.o_cnt0      = w_serial && (r_cnt == 5'd0);
  assign bus.o_cnt1      = w_serial && (r_cnt == 5'd1);
  assign bus.o_cnt_done  = w_serial && (r_cnt == 5'd31);
  assign bus.o_dbus_cyc  = (r_state == ST_BUS);
  assign bus.o_dbus_we   = (r_state == ST_BUS) && r_we;
  assign bus.o_rd_en     = (r_state == ST_RUN);
  assign bus.o_done      = (r_state == ST_DONE);
  assign bus.o_trap      = (r_state == ST_TRAP);
  assign bus.o_bus_err   = (r_state == ST_ERR);

endmodule
